// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared definitions for the register-file access arbiter.
// Contents:
//   state_t       - FSM encoding (IDLE = 1'b0, ACCESS = 1'b1)
//   DEF_DW        - default register data width
//   DEF_NUM_REQ   - default number of requesters
//   DEF_NUM_REGS  - default number of registers in the bank
package rf_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_DW       = 16;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_REGS = 8;

endpackage

// File: rtl/rf_access_arbiter_picker.sv
// rf_rr_picker: combinational round-robin selector.
// Ports:
//   req   in  NUM_REQ          request vector
//   ptr   in  $clog2(NUM_REQ)  index where the search starts
//   valid out 1                at least one request is asserted
//   idx   out $clog2(NUM_REQ)  first asserted request at or above ptr, wrapping
module rf_rr_picker
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  // One extra bit so ptr + k cannot overflow before the wrap correction.
  logic [IW:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: round-robin controller sharing a bank of clock-enabled
// registers between NUM_REQ requesters. Each grant becomes exactly one write
// (one-hot reg_clk_en + reg_d for one cycle) or one read (reg_q sampled into
// rdata with an rvalid strobe). All flops act on the falling edge of clk_n.
// Ports:
//   clk_n, rst_n  clock (falling edge active), async active-low reset
//   req/req_we/req_addr/req_wdata  per-requester operation, packed
//   gnt           one-hot grant pulse
//   reg_clk_en, reg_d, reg_q       register bank interface
//   rdata, rvalid, rid             read result, strobe and requester index
// Build option: RF_ARB_R0_ZERO_EN makes register 0 read as zero and never
// enables its write clock.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DW       = DEF_DW,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                       clk_n,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REGS-1:0]        reg_clk_en,
  output logic [DW-1:0]              reg_d,
  input  logic [NUM_REGS*DW-1:0]     reg_q,
  output logic [DW-1:0]              rdata,
  output logic                       rvalid,
  output logic [$clog2(NUM_REQ)-1:0] rid
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       win;
  logic                we_q;
  logic [AW-1:0]       addr_q;

  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                sel_we;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic [NUM_REGS-1:0] sel_clk_en;
  logic [DW-1:0]       rd_word;

  rf_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel_we    = req_we[pick_idx];
  assign sel_addr  = req_addr[pick_idx*AW +: AW];
  assign sel_wdata = req_wdata[pick_idx*DW +: DW];

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  // Write enable for the winner; out-of-range addresses enable nothing.
  always_comb begin
    sel_clk_en = '0;
    if (sel_we && (int'(sel_addr) < NUM_REGS)) begin
      sel_clk_en[sel_addr] = 1'b1;
    end
`ifdef RF_ARB_R0_ZERO_EN
    if (sel_addr == '0) begin
      sel_clk_en = '0;
    end
`endif
  end

  // Read mux on the latched address; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (int'(addr_q) < NUM_REGS) begin
      rd_word = reg_q[addr_q*DW +: DW];
    end
`ifdef RF_ARB_R0_ZERO_EN
    if (addr_q == '0) begin
      rd_word = '0;
    end
`endif
  end

  // Strobes default low every cycle so gnt, reg_clk_en and rvalid are single
  // cycle pulses; reg_d and rdata only change when a new operation loads them.
  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      win        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      gnt        <= '0;
      reg_clk_en <= '0;
      reg_d      <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      rid        <= '0;
    end else begin
      gnt        <= '0;
      reg_clk_en <= '0;
      rvalid     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win        <= pick_idx;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            gnt        <= pick_onehot;
            reg_clk_en <= sel_clk_en;
            if (sel_we) begin
              reg_d <= sel_wdata;
            end
            ptr   <= (int'(pick_idx) == NUM_REQ-1) ? '0 : pick_idx + 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata  <= rd_word;
            rvalid <= 1'b1;
            rid    <= win;
          end
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter: directed testbench for rf_access_arbiter with a small
// behavioural register bank, a reference memory, and scoreboards of expected
// grants and read results. A second instance with NUM_REGS=6 covers
// out-of-range addresses. Build option: RF_ARB_R0_ZERO_EN.
module tb_rf_access_arbiter;

  localparam int NR = 4;
  localparam int NG = 8;
  localparam int DW = 16;
  localparam int AW = 3;
`ifdef RF_ARB_R0_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef struct {
    int           idx;
    logic         we;
    logic [NG-1:0] clk_en;
    logic [DW-1:0] data;
  } gnt_exp_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic            clk_n = 1'b1;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   gnt;
  logic [NG-1:0]   reg_clk_en;
  logic [DW-1:0]   reg_d;
  logic [NG*DW-1:0] reg_q;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic [1:0]      rid;

  logic [NR-1:0]   req6 = '0;
  logic [NR-1:0]   req6_we = '0;
  logic [NR*AW-1:0] req6_addr = '0;
  logic [NR*DW-1:0] req6_wdata = '0;
  logic [NR-1:0]   gnt6;
  logic [5:0]      reg_clk_en6;
  logic [DW-1:0]   reg_d6;
  logic [6*DW-1:0] reg_q6;
  logic [DW-1:0]   rdata6;
  logic            rvalid6;
  logic [1:0]      rid6;

  logic [DW-1:0]   bank [NG];
  logic [DW-1:0]   mem [NG];

  int total = 0;
  int bad = 0;
  int cycle = 0;
  gnt_exp_t gnt_q[$];
  rd_exp_t  rd_q[$];
  int       gnt_cycles[$];

  rf_access_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .DW(DW)) dut (
    .clk_n(clk_n), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .reg_clk_en(reg_clk_en), .reg_d(reg_d), .reg_q(reg_q),
    .rdata(rdata), .rvalid(rvalid), .rid(rid)
  );

  rf_access_arbiter #(.NUM_REQ(NR), .NUM_REGS(6), .DW(DW)) dut6 (
    .clk_n(clk_n), .rst_n(rst_n), .req(req6), .req_we(req6_we),
    .req_addr(req6_addr), .req_wdata(req6_wdata), .gnt(gnt6),
    .reg_clk_en(reg_clk_en6), .reg_d(reg_d6), .reg_q(reg_q6),
    .rdata(rdata6), .rvalid(rvalid6), .rid(rid6)
  );

  always #5 clk_n = ~clk_n;

  // Register bank: captures reg_d on the falling edge where its enable is high.
  always @(negedge clk_n) begin
    for (int i = 0; i < NG; i++) begin
      if (reg_clk_en[i]) bank[i] <= reg_d;
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_q
    assign reg_q[g*DW +: DW] = bank[g];
  end

  assign reg_q6 = {6{16'hffff}};

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic we, input int addr,
                               input logic [DW-1:0] data, input bit commit);
    gnt_exp_t e;
    rd_exp_t  r;
    req[idx]                 = 1'b1;
    req_we[idx]              = we;
    req_addr[idx*AW +: AW]   = AW'(addr);
    req_wdata[idx*DW +: DW]  = data;
    e.idx    = idx;
    e.we     = we;
    e.data   = data;
    e.clk_en = '0;
    if (we && addr < NG && !(ZERO_EN && addr == 0)) e.clk_en[addr] = 1'b1;
    gnt_q.push_back(e);
    if (we) begin
      if (commit) mem[addr] = data;
    end else begin
      r.idx  = idx;
      r.data = (ZERO_EN && addr == 0) ? '0 : mem[addr];
      rd_q.push_back(r);
    end
  endtask

  task automatic checkOutput();
    gnt_exp_t e;
    rd_exp_t  r;
    cycle++;
    if (gnt != '0) begin
      if (gnt_q.size() == 0) begin
        checkEq("unexpected_gnt", 32'(gnt), 32'h0);
      end else begin
        e = gnt_q.pop_front();
        checkEq("gnt", 32'(gnt), 32'(1) << e.idx);
        checkEq("reg_clk_en", 32'(reg_clk_en), 32'(e.clk_en));
        if (e.we) checkEq("reg_d", 32'(reg_d), 32'(e.data));
        gnt_cycles.push_back(cycle);
      end
    end else begin
      checkEq("idle_clk_en", 32'(reg_clk_en), 32'h0);
    end
    if (rvalid) begin
      if (rd_q.size() == 0) begin
        checkEq("unexpected_rvalid", 32'(rvalid), 32'h0);
      end else begin
        r = rd_q.pop_front();
        checkEq("rdata", 32'(rdata), 32'(r.data));
        checkEq("rid", 32'(rid), 32'(r.idx));
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_n);
      checkOutput();
      req = req & ~gnt;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_gnt"}, 32'(gnt), 32'h0);
    checkEq({tag, "_clk_en"}, 32'(reg_clk_en), 32'h0);
    checkEq({tag, "_reg_d"}, 32'(reg_d), 32'h0);
    checkEq({tag, "_rdata"}, 32'(rdata), 32'h0);
    checkEq({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    checkEq({tag, "_rid"}, 32'(rid), 32'h0);
  endtask

  initial begin
    bit saw_g;
    bit saw_v;
    for (int i = 0; i < NG; i++) mem[i] = '0;

    $display("[TB] reset");
    #2 rst_n = 1'b0;
    #1 checkAllZero("reset");
    runCycles(2);
    rst_n = 1'b1;
    runCycles(1);

    $display("[TB] single write then read");
    applyStimulus(0, 1'b1, 3, 16'h1111, 1'b1);
    runCycles(4);
    applyStimulus(2, 1'b0, 3, '0, 1'b0);
    runCycles(4);

    $display("[TB] wrap-around fairness");
    applyStimulus(3, 1'b1, 5, 16'h5555, 1'b1);
    applyStimulus(1, 1'b1, 6, 16'h6666, 1'b1);
    runCycles(7);

    $display("[TB] four simultaneous writes");
    rst_n = 1'b0;
    runCycles(1);
    rst_n = 1'b1;
    gnt_cycles.delete();
    applyStimulus(0, 1'b1, 0, 16'h1111, 1'b1);
    applyStimulus(1, 1'b1, 1, 16'h2222, 1'b1);
    applyStimulus(2, 1'b1, 2, 16'h4444, 1'b1);
    applyStimulus(3, 1'b1, 3, 16'h8888, 1'b1);
    runCycles(11);
    checkEq("grant_count", 32'(gnt_cycles.size()), 32'd4);
    for (int i = 1; i < gnt_cycles.size(); i++) begin
      checkEq("grant_spacing", 32'(gnt_cycles[i] - gnt_cycles[i-1]), 32'd2);
    end
    applyStimulus(3, 1'b0, 2, '0, 1'b0);
    runCycles(4);
    applyStimulus(1, 1'b0, 3, '0, 1'b0);
    runCycles(4);

    $display("[TB] reset during write access");
    applyStimulus(0, 1'b1, 5, 16'hcccc, 1'b0);
    runCycles(1);
    rst_n = 1'b0;
    #1 checkAllZero("mid_reset");
    runCycles(2);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 5, '0, 1'b0);
    runCycles(4);

    $display("[TB] address zero");
    applyStimulus(1, 1'b1, 0, 16'hffff, 1'b1);
    runCycles(4);
    applyStimulus(1, 1'b0, 0, '0, 1'b0);
    runCycles(4);

    $display("[TB] out-of-range read on six-register instance");
    req6 = 4'b0001;
    req6_we = 4'b0000;
    req6_addr = 12'h007;
    saw_g = 1'b0;
    saw_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_n);
      checkEq("r6_clk_en", 32'(reg_clk_en6), 32'h0);
      if (gnt6 != '0) begin
        checkEq("r6_gnt", 32'(gnt6), 32'h1);
        saw_g = 1'b1;
        req6 = '0;
      end
      if (rvalid6) begin
        checkEq("r6_rdata", 32'(rdata6), 32'h0);
        checkEq("r6_rid", 32'(rid6), 32'h0);
        saw_v = 1'b1;
      end
    end
    checkEq("r6_granted", 32'(saw_g), 32'h1);
    checkEq("r6_rvalid_seen", 32'(saw_v), 32'h1);
    checkEq("r6_reg_d", 32'(reg_d6), 32'h0);

    checkEq("gnt_queue_drained", 32'(gnt_q.size()), 32'h0);
    checkEq("rd_queue_drained", 32'(rd_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
